// File: rtl/myfilter_pkg.sv
// myfilter_pkg: sample width, sequencer state type and accumulator sizing shared by the filter_sequencer slice
package myfilter_pkg;
  localparam int DATABITS = 8;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  function automatic int acc_width(input int databits, input int coefbits, input int ntaps);
    return databits + coefbits + $clog2(ntaps);
  endfunction
endpackage

// File: rtl/filter_sequencer_if.sv
// filter_sequencer_if: input/output sample streams, coefficient config port and busy flag
interface filter_sequencer_if #(parameter int NTAPS = 8, parameter int COEFBITS = 8);
  import myfilter_pkg::*;
  logic signed [DATABITS-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic signed [DATABITS-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic cfg_we;
  logic [$clog2(NTAPS)-1:0] cfg_addr;
  logic signed [COEFBITS-1:0] cfg_data;
  logic cfg_commit;
  logic busy;
  modport master (
    output in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data, cfg_commit,
    input in_ready, out_data, out_valid, busy
  );
  modport slave (
    input in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data, cfg_commit,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/filter_mac.sv
// filter_mac: signed sample x coefficient product feeding a clearable, enabled accumulator
module filter_mac #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int ACCW = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic signed [DW-1:0]   i_data,
  input  logic signed [CW-1:0]   i_coef,
  output logic signed [ACCW-1:0] o_acc_next
);
  logic signed [DW+CW-1:0] w_prod;
  logic signed [ACCW-1:0] r_acc;
  assign w_prod = i_data * i_coef;
  assign o_acc_next = r_acc + {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
  // accumulator: cleared on sample accept, advanced once per MAC step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en) r_acc <= o_acc_next;
endmodule

// File: rtl/filter_sequencer.sv
// filter_sequencer: time-multiplexed FIR controller; define FILTER_SATURATE_EN to clamp results instead of wrapping
module filter_sequencer
  import myfilter_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int COEFBITS = 8
) (
  input logic clk,
  input logic rst_n,
  filter_sequencer_if.slave bus
);
  localparam int AW = $clog2(NTAPS);
  localparam int ACCW = acc_width(DATABITS, COEFBITS, NTAPS);
  state_t r_state;
  logic [AW-1:0] r_wr_ptr, r_tap, w_idx;
  logic signed [DATABITS-1:0] r_dline [NTAPS];
  logic signed [COEFBITS-1:0] r_shadow [NTAPS];
  logic signed [COEFBITS-1:0] r_active [NTAPS];
  logic r_commit_pend, r_out_valid, r_busy;
  logic signed [DATABITS-1:0] r_out_data, w_result;
  logic signed [ACCW-1:0] w_acc_next;
  logic w_accept, w_last, w_copy, w_unused;
  assign bus.in_ready = (r_state == IDLE) && !r_commit_pend && !bus.cfg_commit;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.busy = r_busy;
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last = r_tap == AW'(NTAPS - 1);
  assign w_idx = r_wr_ptr - AW'(1) - r_tap;
  assign w_copy = (r_state == IDLE) && (bus.cfg_commit || r_commit_pend);
  filter_mac #(.DW(DATABITS), .CW(COEFBITS), .ACCW(ACCW)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_en      (r_state == MAC),
    .i_data    (r_dline[w_idx]),
    .i_coef    (r_active[r_tap]),
    .o_acc_next(w_acc_next)
  );
  // result is acc >>> (COEFBITS-1): bit k of the shifted value is acc bit k+COEFBITS-1
`ifdef FILTER_SATURATE_EN
  logic w_ovf;
  assign w_ovf = !(&w_acc_next[ACCW-1:DATABITS+COEFBITS-2]) && (|w_acc_next[ACCW-1:DATABITS+COEFBITS-2]);
  assign w_result = w_ovf ? {w_acc_next[ACCW-1], {(DATABITS-1){~w_acc_next[ACCW-1]}}}
                          : w_acc_next[COEFBITS-1 +: DATABITS];
  assign w_unused = ^w_acc_next[COEFBITS-2:0];
`else
  assign w_result = w_acc_next[COEFBITS-1 +: DATABITS];
  assign w_unused = ^{w_acc_next[ACCW-1:DATABITS+COEFBITS-1], w_acc_next[COEFBITS-2:0]};
`endif
  // sequencer FSM: accept a sample, walk the taps, hold the result until taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_tap <= '0;
      r_wr_ptr <= '0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= MAC;
          r_tap <= '0;
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_busy <= 1'b1;
        end
        MAC: begin
          r_tap <= r_tap + AW'(1);
          if (w_last) begin
            r_state <= OUT;
            r_out_valid <= 1'b1;
            r_out_data <= w_result;
          end
        end
        OUT: if (bus.out_ready) begin
          r_state <= IDLE;
          r_out_valid <= 1'b0;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  // circular delay line written at the accept edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NTAPS; i++) r_dline[i] <= '0;
    else if (w_accept) r_dline[r_wr_ptr] <= bus.in_data;
  // coefficient banks: the copy reads shadow before any same-edge write, so a coincident write is not committed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_commit_pend <= 1'b0;
    end else begin
      if (bus.cfg_we) r_shadow[bus.cfg_addr] <= bus.cfg_data;
      if (w_copy) for (int i = 0; i < NTAPS; i++) r_active[i] <= r_shadow[i];
      r_commit_pend <= (r_state != IDLE) && (r_commit_pend || bus.cfg_commit);
    end
endmodule

// File: tb/tb_filter_sequencer.sv
// tb_filter_sequencer: directed and randomized checks of filter_sequencer against a tap-sum reference model
module tb_filter_sequencer;
  localparam int NT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int shadow [NT];
  int active [NT];
  int hist [$];
  bit pend;
  int e;
  always #5 clk = ~clk;
  filter_sequencer_if #(.NTAPS(NT), .COEFBITS(8)) bus ();
  filter_sequencer #(.NTAPS(NT), .COEFBITS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      shadow[i] = 0;
      active[i] = 0;
    end
    hist.delete();
    pend = 0;
  endfunction
  // y = (sum of coef[k] * x[n-k]) >>> 7, then clamp or wrap to 8 bits
  function automatic int model_out();
    longint acc = 0;
    logic signed [7:0] t;
    for (int k = 0; k < NT; k++)
      if (k < hist.size()) acc += longint'(active[k]) * longint'(hist[k]);
    acc = acc >>> 7;
`ifdef FILTER_SATURATE_EN
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
`endif
    t = acc[7:0];
    return int'(t);
  endfunction
  task automatic cfg(input bit we, input int a, input logic signed [7:0] v, input bit cm, input bit in_flight);
    bus.cfg_we = we;
    bus.cfg_addr = a[1:0];
    bus.cfg_data = v;
    bus.cfg_commit = cm;
    if (cm) begin
      #1;
      chk("in_ready_commit_cycle", bus.in_ready, 0);
    end
    step();
    bus.cfg_we = 1'b0;
    bus.cfg_commit = 1'b0;
    if (cm) begin
      if (in_flight) pend = 1;
      else active = shadow;
    end
    if (we) shadow[a] = int'(v);
  endtask
  task automatic send(input logic signed [7:0] x, output int exp);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("in_ready_before_accept", bus.in_ready, 1);
    if (pend) begin
      active = shadow;
      pend = 0;
    end
    bus.in_data = x;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    hist.push_front(int'(x));
    if (hist.size() > NT) void'(hist.pop_back());
    exp = model_out();
  endtask
  task automatic collect(input string tag, input int exp, input bit lat, input int hold);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    if (lat) chk({tag, "_latency"}, n, NT);
    chk({tag, "_data"}, bus.out_data, exp);
    chk({tag, "_in_ready_low"}, bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_data"}, bus.out_data, exp);
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
      chk({tag, "_hold_busy"}, bus.busy, 1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_busy_drop"}, bus.busy, 0);
  endtask
  initial begin
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.cfg_commit = 1'b0;
    model_reset();
    step();
    step();
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    step();
    cfg(1, 0, 8'sd64, 0, 0);
    cfg(1, 1, 8'sd64, 0, 0);
    cfg(0, 0, 8'sd0, 1, 0);
    send(8'sd10, e);
    collect("basic0", 5, 1, 0);
    send(8'sd20, e);
    collect("basic1", 15, 1, 0);
    for (int a = 0; a < NT; a++) cfg(1, a, 8'sd127, 0, 0);
    cfg(0, 0, 8'sd0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      send(8'sd127, e);
`ifdef FILTER_SATURATE_EN
      collect("ovf", (i == 3) ? 127 : e, 1, 0);
`else
      collect("ovf", (i == 3) ? -8 : e, 1, 0);
`endif
    end
    send(8'sd33, e);
    collect("bp", e, 1, 5);
    cfg(1, 0, 8'sd64, 0, 0);
    cfg(1, 1, 8'sd64, 0, 0);
    cfg(1, 2, 8'sd0, 0, 0);
    cfg(1, 3, 8'sd0, 0, 0);
    cfg(0, 0, 8'sd0, 1, 0);
    send(8'sd40, e);
    cfg(1, 0, 8'sd127, 0, 1);
    cfg(1, 1, 8'sd0, 0, 1);
    cfg(0, 0, 8'sd0, 1, 1);
    collect("cwb_old", e, 0, 0);
    chk("in_ready_pending_copy", bus.in_ready, 0);
    send(8'sd50, e);
    collect("cwb_new", e, 1, 0);
    cfg(1, 1, 8'sd64, 0, 0);
    cfg(1, 0, 8'sd32, 1, 0);
    send(-8'sd20, e);
    collect("we_commit_same", e, 1, 0);
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < NT; a++) cfg(1, a, 8'($urandom), 0, 0);
      cfg(0, 0, 8'sd0, 1, 0);
      for (int s = 0; s < 6; s++) begin
        send(8'($urandom), e);
        collect("rand", e, 1, int'($urandom_range(0, 2)));
      end
    end
    send(8'sd100, e);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midmac_rst_out_valid", bus.out_valid, 0);
    chk("midmac_rst_out_data", bus.out_data, 0);
    chk("midmac_rst_in_ready", bus.in_ready, 1);
    chk("midmac_rst_busy", bus.busy, 0);
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    send(8'sd77, e);
    collect("post_reset", 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
